jtag_dtm_dmi: RTL and testbench

JTAG_DTM_DMI -- requirements
Module: jtag_dtm_dmi

---
 rtl/jtag_dtm_pkg.sv | 22 ++
 rtl/jtag_dtm_dmi_if.sv | 26 ++
 rtl/jtag_dtm_sr.sv | 30 +++
 rtl/jtag_dtm_dmi.sv | 154 +++++++++++++++
 tb/tb_jtag_dtm_dmi.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dtm_pkg.sv
// Shared encodings for the JTAG debug transport: DMI ops, status codes,
// FSM states and DTMCS control-bit positions.
package jtag_dtm_pkg;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [1:0] STAT_OK     = 2'd0;
  localparam logic [1:0] STAT_FAILED = 2'd2;
  localparam logic [1:0] STAT_BUSY   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dtm_state_e;

  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;

endpackage

// File: rtl/jtag_dtm_dmi_if.sv
// DMI request/response bus between the DTM (master) and the debug module (slave).
interface jtag_dtm_dmi_if #(
  parameter int ABITS = 7
) ();

  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;
  logic             dmi_rsp_valid;
  logic [31:0]      dmi_rsp_data;
  logic [1:0]       dmi_rsp_op;
  logic             dmi_hard_reset;

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_hard_reset,
    input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_hard_reset,
    output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op
  );

endinterface

// File: rtl/jtag_dtm_sr.sv
// JTAG data-register shift chain: parallel capture, LSB-first shift (tdi into MSB).
// One-edge capture/shift latency; holds its value when not selected.
module jtag_dtm_sr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic [WIDTH-1:0] cap_val,
  output logic [WIDTH-1:0] val
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (sel && capture) begin
      sr <= cap_val;
    end else if (sel && shift) begin
      sr <= {tdi, sr[WIDTH-1:1]};
    end
  end

  assign val = sr;

endmodule

// File: rtl/jtag_dtm_dmi.sv
// JTAG DTM: DTMCS/DMI chains driving a single-outstanding DMI request; request is
// valid one tck after the DMI update and waits on dmi_req_ready, response on dmi_rsp_valid.
module jtag_dtm_dmi
  import jtag_dtm_pkg::*;
#(
  parameter int         ABITS     = 7,
  parameter logic [2:0] IDLE_HINT = 3'd1,
  parameter logic [3:0] VERSION   = 4'd1
) (
  input  logic           jtag_tck,
  input  logic           jtag_trst_n,
  input  logic           tap_capture,
  input  logic           tap_shift,
  input  logic           tap_update,
  input  logic           tap_tdi,
  input  logic           sel_dtmcs,
  input  logic           sel_dmi,
  output logic           tap_tdo,
  jtag_dtm_dmi_if.master dmi
);

  localparam int DW = ABITS + 34;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_RSP  = ST_RSP;

  logic [1:0]       state;
  logic [1:0]       dmistat;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      rsp_data_reg;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic [1:0]       req_op;
  logic             hard_reset;

  logic [31:0]      dtmcs_cap;
  logic [31:0]      dtmcs_val;
  logic [DW-1:0]    dmi_cap;
  logic [DW-1:0]    dmi_val;
  logic [1:0]       dmi_status;

  logic             dtmcs_upd;
  logic             dmi_upd;
  logic             dmi_cap_busy;
  logic [1:0]       upd_op;
  logic [31:0]      upd_data;
  logic [ABITS-1:0] upd_addr;
  logic             unused_dtmcs;

  // Sticky error wins; otherwise report busy while a request is outstanding.
  assign dmi_status = (dmistat != STAT_OK) ? dmistat :
                      (state != S_IDLE)    ? STAT_BUSY : STAT_OK;

  assign dtmcs_cap = {14'h0, 2'b00, 1'b0, IDLE_HINT, dmistat, 6'(ABITS), VERSION};
  assign dmi_cap   = {last_addr, rsp_data_reg, dmi_status};

  jtag_dtm_sr #(.WIDTH(32)) u_dtmcs_sr (
    .clk     (jtag_tck),
    .rst     (jtag_trst_n),
    .sel     (sel_dtmcs),
    .capture (tap_capture),
    .shift   (tap_shift),
    .tdi     (tap_tdi),
    .cap_val (dtmcs_cap),
    .val     (dtmcs_val)
  );

  jtag_dtm_sr #(.WIDTH(DW)) u_dmi_sr (
    .clk     (jtag_tck),
    .rst     (jtag_trst_n),
    .sel     (sel_dmi),
    .capture (tap_capture),
    .shift   (tap_shift),
    .tdi     (tap_tdi),
    .cap_val (dmi_cap),
    .val     (dmi_val)
  );

  assign tap_tdo = sel_dtmcs ? dtmcs_val[0] :
                   sel_dmi   ? dmi_val[0]   : tap_tdi;

  assign dtmcs_upd    = tap_update & sel_dtmcs;
  assign dmi_upd      = tap_update & sel_dmi;
  assign dmi_cap_busy = tap_capture & sel_dmi & (state != S_IDLE);
  assign upd_op       = dmi_val[1:0];
  assign upd_data     = dmi_val[33:2];
  assign upd_addr     = dmi_val[DW-1:34];
  assign unused_dtmcs = ^{dtmcs_val[31:18], dtmcs_val[15:1]};

  always_ff @(posedge jtag_tck or posedge jtag_trst_n) begin
    if (jtag_trst_n) begin
      state        <= S_IDLE;
      dmistat      <= STAT_OK;
      last_addr    <= '0;
      rsp_data_reg <= '0;
      req_addr     <= '0;
      req_data     <= '0;
      req_op       <= OP_NOP;
      hard_reset   <= 1'b0;
    end else begin
      hard_reset <= 1'b0;
      if (dtmcs_upd && dtmcs_val[DTMCS_HARDRESET_BIT]) begin
        hard_reset <= 1'b1;
        dmistat    <= STAT_OK;
        state      <= S_IDLE;
      end else begin
        if (dtmcs_upd && dtmcs_val[DTMCS_DMIRESET_BIT]) begin
          dmistat <= STAT_OK;
        end
        case (state)
          S_IDLE: begin
            if (dmi_upd && dmistat == STAT_OK &&
                (upd_op == OP_READ || upd_op == OP_WRITE)) begin
              req_addr  <= upd_addr;
              req_data  <= upd_data;
              req_op    <= upd_op;
              last_addr <= upd_addr;
              state     <= S_REQ;
            end
          end
          S_REQ: begin
            if (dmi.dmi_req_ready) begin
              state <= S_RSP;
            end
          end
          S_RSP: begin
            if (dmi.dmi_rsp_valid) begin
              rsp_data_reg <= dmi.dmi_rsp_data;
              state        <= S_IDLE;
              if (dmi.dmi_rsp_op == STAT_FAILED) begin
                dmistat <= STAT_FAILED;
              end else if (dmi.dmi_rsp_op == STAT_BUSY) begin
                dmistat <= STAT_BUSY;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
        // Touching the DMI chain mid-transaction means the host is polling too fast.
        if ((dmi_upd || dmi_cap_busy) && state != S_IDLE) begin
          dmistat <= STAT_BUSY;
        end
      end
    end
  end

  assign dmi.dmi_req_valid  = (state == S_REQ);
  assign dmi.dmi_req_addr   = req_addr;
  assign dmi.dmi_req_data   = req_data;
  assign dmi.dmi_req_op     = req_op;
  assign dmi.dmi_hard_reset = hard_reset;

endmodule

// File: tb/tb_jtag_dtm_dmi.sv
// Scenario bench for jtag_dtm_dmi: directed cases plus randomized DMI traffic
// scored against a transaction-level model of status, last address and read data.
module tb_jtag_dtm_dmi;
  import jtag_dtm_pkg::*;

  localparam int ABITS = 7;
  localparam int DW    = ABITS + 34;

  logic jtag_tck = 1'b0;
  logic jtag_trst_n;
  logic tap_capture, tap_shift, tap_update, tap_tdi;
  logic sel_dtmcs, sel_dmi;
  logic tap_tdo;

  int checks   = 0;
  int failures = 0;

  // Model: sticky status, whether a request is outstanding, and captured fields.
  logic [1:0]       m_stat;
  bit               m_out;
  logic [ABITS-1:0] m_last_addr;
  logic [31:0]      m_rsp_data;

  jtag_dtm_dmi_if #(.ABITS(ABITS)) dmi ();

  jtag_dtm_dmi #(.ABITS(ABITS), .IDLE_HINT(3'd1), .VERSION(4'd1)) dut (
    .jtag_tck    (jtag_tck),
    .jtag_trst_n (jtag_trst_n),
    .tap_capture (tap_capture),
    .tap_shift   (tap_shift),
    .tap_update  (tap_update),
    .tap_tdi     (tap_tdi),
    .sel_dtmcs   (sel_dtmcs),
    .sel_dmi     (sel_dmi),
    .tap_tdo     (tap_tdo),
    .dmi         (dmi)
  );

  always #5 jtag_tck = ~jtag_tck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_dtmcs(input logic [1:0] st);
    logic [31:0] v;
    v = 32'h0;
    v[3:0]   = 4'd1;
    v[9:4]   = 6'(ABITS);
    v[11:10] = st;
    v[14:12] = 3'd1;
    return v;
  endfunction

  task automatic model_reset();
    m_stat = 2'd0; m_out = 1'b0; m_last_addr = '0; m_rsp_data = '0;
  endtask

  // Expected DMI capture; capturing with a request in flight makes status sticky busy.
  task automatic model_dmi_capture(output logic [DW-1:0] v);
    logic [1:0] st;
    st = (m_stat != 2'd0) ? m_stat : (m_out ? 2'd3 : 2'd0);
    v  = {m_last_addr, m_rsp_data, st};
    if (m_out) m_stat = 2'd3;
  endtask

  task automatic scan_dr(input bit use_dmi, input int n, input logic [63:0] din,
                         output logic [63:0] dout);
    dout = '0;
    sel_dtmcs = !use_dmi; sel_dmi = use_dmi; tap_capture = 1'b1;
    @(negedge jtag_tck);
    tap_capture = 1'b0; tap_shift = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i] = tap_tdo;
      tap_tdi = din[i];
      @(negedge jtag_tck);
    end
    tap_shift = 1'b0; tap_update = 1'b1;
    @(negedge jtag_tck);
    tap_update = 1'b0; sel_dtmcs = 1'b0; sel_dmi = 1'b0;
  endtask

  task automatic scan_dmi(input logic [ABITS-1:0] a, input logic [31:0] d,
                          input logic [1:0] o, output logic [DW-1:0] cap);
    logic [63:0] dout;
    scan_dr(1'b1, DW, 64'({a, d, o}), dout);
    cap = dout[DW-1:0];
  endtask

  task automatic scan_dtmcs(input logic [31:0] din, output logic [31:0] cap);
    logic [63:0] dout;
    scan_dr(1'b0, 32, {32'h0, din}, dout);
    cap = dout[31:0];
  endtask

  task automatic dm_accept(input int dly, output int vc, output logic [ABITS-1:0] a,
                           output logic [31:0] d, output logic [1:0] o);
    int waited;
    logic [ABITS+33:0] first;
    waited = 0; vc = 0; a = '0; d = '0; o = '0; first = '0;
    while (waited < 40) begin
      if (dmi.dmi_req_valid) begin
        vc++;
        if (vc == 1) first = {dmi.dmi_req_addr, dmi.dmi_req_data, dmi.dmi_req_op};
        if (vc > dly) begin
          a = dmi.dmi_req_addr; d = dmi.dmi_req_data; o = dmi.dmi_req_op;
          checks++;
          if ({a, d, o} !== first) begin
            failures++;
            $display("FAIL req_stable: fields %h at handshake, required %h", {a, d, o}, first);
          end
          dmi.dmi_req_ready = 1'b1;
          @(negedge jtag_tck);
          dmi.dmi_req_ready = 1'b0;
          return;
        end
      end
      waited++;
      @(negedge jtag_tck);
    end
    checks++; failures++;
    $display("FAIL dm_accept: no request handshake within %0d cycles, required one", waited);
  endtask

  task automatic dm_respond(input logic [31:0] d, input logic [1:0] o);
    dmi.dmi_rsp_valid = 1'b1; dmi.dmi_rsp_data = d; dmi.dmi_rsp_op = o;
    @(negedge jtag_tck);
    dmi.dmi_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    jtag_trst_n = 1'b1;
    tap_capture = 0; tap_shift = 0; tap_update = 0; tap_tdi = 0;
    sel_dtmcs = 0; sel_dmi = 0;
    dmi.dmi_req_ready = 0; dmi.dmi_rsp_valid = 0; dmi.dmi_rsp_data = '0; dmi.dmi_rsp_op = '0;
    repeat (2) @(negedge jtag_tck);
    checks++;
    if (dmi.dmi_req_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b, required 0", dmi.dmi_req_valid);
    end
    checks++;
    if ({dmi.dmi_req_addr, dmi.dmi_req_data, dmi.dmi_req_op} !== '0) begin
      failures++;
      $display("FAIL reset_req_fields: got %h, required 0",
               {dmi.dmi_req_addr, dmi.dmi_req_data, dmi.dmi_req_op});
    end
    checks++;
    if (dmi.dmi_hard_reset !== 1'b0) begin
      failures++; $display("FAIL reset_hard_reset: got %b, required 0", dmi.dmi_hard_reset);
    end
    tap_tdi = 1'b1; #1;
    checks++;
    if (tap_tdo !== 1'b1) begin
      failures++; $display("FAIL tdo_bypass: got %b, required 1", tap_tdo);
    end
    tap_tdi = 1'b0;
    @(negedge jtag_tck);
    jtag_trst_n = 1'b0;
    model_reset();
    @(negedge jtag_tck);
  endtask

  task automatic test_dtmcs_capture();
    logic [31:0] cap;
    scan_dtmcs(32'h0, cap);
    checks++;
    if (cap !== 32'h0000_1071) begin
      failures++; $display("FAIL dtmcs_capture: got %h, required 00001071", cap);
    end
  endtask

  task automatic test_write();
    logic [DW-1:0] cap, exp;
    int vc; logic [ABITS-1:0] a; logic [31:0] d; logic [1:0] o;
    model_dmi_capture(exp);
    scan_dmi(7'h10, 32'hDEAD_BEEF, OP_WRITE, cap);
    checks++;
    if (cap !== exp) begin
      failures++; $display("FAIL write_prev_capture: got %h, required %h", cap, exp);
    end
    checks++;
    if (dmi.dmi_req_valid !== 1'b1) begin
      failures++; $display("FAIL req_latency: valid %b one edge after update, required 1", dmi.dmi_req_valid);
    end
    m_out = 1'b1; m_last_addr = 7'h10;
    dm_accept(2, vc, a, d, o);
    checks++;
    if (vc != 3) begin
      failures++; $display("FAIL write_valid_cycles: got %0d, required 3", vc);
    end
    checks++;
    if ({a, d, o} !== {7'h10, 32'hDEAD_BEEF, OP_WRITE}) begin
      failures++; $display("FAIL write_fields: got %h, required %h", {a, d, o}, {7'h10, 32'hDEAD_BEEF, OP_WRITE});
    end
    checks++;
    if (dmi.dmi_req_valid !== 1'b0) begin
      failures++; $display("FAIL write_valid_drop: got %b, required 0", dmi.dmi_req_valid);
    end
    repeat (2) @(negedge jtag_tck);
    dm_respond(32'h0000_0000, STAT_OK);
    m_out = 1'b0; m_rsp_data = 32'h0;
    model_dmi_capture(exp);
    scan_dmi('0, '0, OP_NOP, cap);
    checks++;
    if (cap !== exp || cap[1:0] !== 2'd0) begin
      failures++; $display("FAIL write_status: got %h, required %h", cap, exp);
    end
  endtask

  task automatic test_read();
    logic [DW-1:0] cap, exp;
    int vc; logic [ABITS-1:0] a; logic [31:0] d; logic [1:0] o;
    scan_dmi(7'h11, 32'h0, OP_READ, cap);
    m_out = 1'b1; m_last_addr = 7'h11;
    dm_accept(0, vc, a, d, o);
    checks++;
    if (vc != 1 || a !== 7'h11 || o !== OP_READ) begin
      failures++; $display("FAIL read_req: cycles %0d addr %h op %0d, required 1 11 1", vc, a, o);
    end
    dm_respond(32'h1234_5678, STAT_OK);
    m_out = 1'b0; m_rsp_data = 32'h1234_5678;
    model_dmi_capture(exp);
    scan_dmi('0, '0, OP_NOP, cap);
    checks++;
    if (cap[33:2] !== 32'h1234_5678 || cap[1:0] !== 2'd0 || cap !== exp) begin
      failures++; $display("FAIL read_capture: got %h, required %h", cap, exp);
    end
  endtask

  task automatic test_busy();
    logic [DW-1:0] cap, exp;
    logic [31:0] dcap;
    int vc, highs; logic [ABITS-1:0] a; logic [31:0] d; logic [1:0] o;
    scan_dmi(7'h22, 32'h0, OP_READ, cap);
    m_out = 1'b1; m_last_addr = 7'h22;
    dm_accept(1, vc, a, d, o);
    model_dmi_capture(exp);
    scan_dmi(7'h23, 32'hCAFE_0001, OP_WRITE, cap);
    m_stat = 2'd3;
    checks++;
    if (cap !== exp) begin
      failures++; $display("FAIL busy_capture_in_rsp: got %h, required %h", cap, exp);
    end
    dm_respond(32'hA5A5_5A5A, STAT_OK);
    m_out = 1'b0; m_rsp_data = 32'hA5A5_5A5A;
    highs = 0;
    repeat (4) begin
      if (dmi.dmi_req_valid) highs++;
      @(negedge jtag_tck);
    end
    checks++;
    if (highs != 0) begin
      failures++; $display("FAIL busy_no_launch: valid high %0d cycles, required 0", highs);
    end
    model_dmi_capture(exp);
    scan_dmi('0, '0, OP_NOP, cap);
    checks++;
    if (cap !== exp || cap[1:0] !== 2'd3) begin
      failures++; $display("FAIL busy_dmi_status: got %h, required %h", cap, exp);
    end
    scan_dtmcs(32'h0, dcap);
    checks++;
    if (dcap !== exp_dtmcs(2'd3)) begin
      failures++; $display("FAIL busy_dtmcs_status: got %h, required %h", dcap, exp_dtmcs(2'd3));
    end
  endtask

  task automatic test_dmireset();
    logic [DW-1:0] cap, exp;
    logic [31:0] dcap;
    int vc; logic [ABITS-1:0] a; logic [31:0] d; logic [1:0] o;
    scan_dtmcs(32'h0001_0000, dcap);
    checks++;
    if (dcap !== exp_dtmcs(m_stat)) begin
      failures++; $display("FAIL dmireset_before: got %h, required %h", dcap, exp_dtmcs(m_stat));
    end
    m_stat = 2'd0;
    scan_dtmcs(32'h0, dcap);
    checks++;
    if (dcap !== exp_dtmcs(2'd0)) begin
      failures++; $display("FAIL dmireset_after: got %h, required %h", dcap, exp_dtmcs(2'd0));
    end
    model_dmi_capture(exp);
    scan_dmi(7'h05, 32'h0, OP_READ, cap);
    checks++;
    if (cap !== exp || dmi.dmi_req_valid !== 1'b1) begin
      failures++; $display("FAIL dmireset_launch: capture %h valid %b, required %h 1", cap, dmi.dmi_req_valid, exp);
    end
    m_out = 1'b1; m_last_addr = 7'h05;
    dm_accept(0, vc, a, d, o);
    dm_respond(32'h0505_0505, STAT_OK);
    m_out = 1'b0; m_rsp_data = 32'h0505_0505;
  endtask

  task automatic test_hardreset();
    logic [DW-1:0] cap, exp;
    logic [31:0] dcap;
    model_dmi_capture(exp);
    scan_dmi(7'h33, 32'h1357_9BDF, OP_WRITE, cap);
    m_out = 1'b1; m_last_addr = 7'h33;
    repeat (2) @(negedge jtag_tck);
    scan_dtmcs(32'h0002_0000, dcap);
    checks++;
    if (dmi.dmi_hard_reset !== 1'b1 || dmi.dmi_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL hardreset_edge: pulse %b valid %b, required 1 0", dmi.dmi_hard_reset, dmi.dmi_req_valid);
    end
    @(negedge jtag_tck);
    checks++;
    if (dmi.dmi_hard_reset !== 1'b0) begin
      failures++; $display("FAIL hardreset_width: pulse %b second cycle, required 0", dmi.dmi_hard_reset);
    end
    m_out = 1'b0; m_stat = 2'd0;
    dm_respond(32'hFFFF_0000, STAT_BUSY);
    model_dmi_capture(exp);
    scan_dmi('0, '0, OP_NOP, cap);
    checks++;
    if (cap !== exp) begin
      failures++; $display("FAIL hardreset_late_rsp: got %h, required %h", cap, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] cap, exp;
    scan_dmi(7'h44, 32'h0, OP_READ, cap);
    checks++;
    if (dmi.dmi_req_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_launch: valid %b, required 1", dmi.dmi_req_valid);
    end
    jtag_trst_n = 1'b1;
    #1;
    checks++;
    if (dmi.dmi_req_valid !== 1'b0 || dmi.dmi_req_addr !== '0) begin
      failures++; $display("FAIL midreset_drop: valid %b addr %h, required 0 0", dmi.dmi_req_valid, dmi.dmi_req_addr);
    end
    @(negedge jtag_tck);
    jtag_trst_n = 1'b0;
    model_reset();
    @(negedge jtag_tck);
    dm_respond(32'h7777_7777, STAT_FAILED);
    model_dmi_capture(exp);
    scan_dmi('0, '0, OP_NOP, cap);
    checks++;
    if (cap !== exp) begin
      failures++; $display("FAIL midreset_late_rsp: got %h, required %h", cap, exp);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] cap, exp;
    logic [31:0] dcap;
    logic [ABITS-1:0] ra, a;
    logic [31:0] rd, rsp, d;
    logic [1:0] rop, o, rsp_op;
    int dly, vc, highs, pick;
    bit launch;
    for (int it = 0; it < 24; it++) begin
      ra = ABITS'($urandom); rd = $urandom; rop = 2'($urandom_range(0, 3));
      dly = $urandom_range(0, 3); rsp = $urandom;
      pick = $urandom_range(0, 3);
      rsp_op = (pick == 2) ? STAT_FAILED : (pick == 3) ? STAT_BUSY : STAT_OK;
      launch = (rop == OP_READ || rop == OP_WRITE) && m_stat == 2'd0;
      model_dmi_capture(exp);
      scan_dmi(ra, rd, rop, cap);
      checks++;
      if (cap !== exp) begin
        failures++; $display("FAIL rand_capture[%0d]: got %h, required %h", it, cap, exp);
      end
      if (launch) begin
        m_out = 1'b1; m_last_addr = ra;
        dm_accept(dly, vc, a, d, o);
        checks++;
        if (vc != dly + 1 || {a, d, o} !== {ra, rd, rop}) begin
          failures++;
          $display("FAIL rand_req[%0d]: cycles %0d fields %h, required %0d %h", it, vc, {a, d, o}, dly + 1, {ra, rd, rop});
        end
        repeat ($urandom_range(0, 2)) @(negedge jtag_tck);
        dm_respond(rsp, rsp_op);
        m_out = 1'b0; m_rsp_data = rsp;
        if (rsp_op != STAT_OK) m_stat = rsp_op;
      end else begin
        highs = 0;
        repeat (3) begin
          if (dmi.dmi_req_valid) highs++;
          @(negedge jtag_tck);
        end
        checks++;
        if (highs != 0) begin
          failures++; $display("FAIL rand_no_launch[%0d]: valid high %0d cycles, required 0", it, highs);
        end
      end
      if (m_stat != 2'd0 && $urandom_range(0, 1) == 1) begin
        scan_dtmcs(32'h0001_0000, dcap);
        checks++;
        if (dcap !== exp_dtmcs(m_stat)) begin
          failures++; $display("FAIL rand_dtmcs[%0d]: got %h, required %h", it, dcap, exp_dtmcs(m_stat));
        end
        m_stat = 2'd0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_dtmcs_capture();
    test_write();
    test_read();
    test_busy();
    test_dmireset();
    test_hardreset();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
